// File: rtl/hazard_forward_ctrl.sv
// Forwarding selects and load-use/RAW hazard control for the OTTER pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush/forward counters.
module hazard_forward_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int LOAD_STALL = 1,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] de_rs1,
  input  logic [ADDR_W-1:0] de_rs2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [ADDR_W-1:0] ex_rs1,
  input  logic [ADDR_W-1:0] ex_rs2,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              pc_hold,
  output logic              if_de_hold,
  output logic              de_ex_bubble,
  output logic              if_de_flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  fwd_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [3:0] STALL_INIT =
    4'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic mem_wr_v;
  logic wb_wr_v;
  logic a_mem;
  logic a_wb;
  logic b_mem;
  logic b_wb;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  assign mem_wr_v = mem_regwrite && (mem_rd != '0);
  assign wb_wr_v  = wb_regwrite && (wb_rd != '0);

  assign a_mem = mem_wr_v && (mem_rd == ex_rs1);
  assign a_wb  = wb_wr_v && (wb_rd == ex_rs1);
  assign b_mem = mem_wr_v && (mem_rd == ex_rs2);
  assign b_wb  = wb_wr_v && (wb_rd == ex_rs2);

  // MEM holds the younger result, so it wins over WB
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (FWD_EN != 0) begin
      unique case (1'b1)
        a_mem:          fwd_a_c = 2'b01;
        (a_wb && !a_mem): fwd_a_c = 2'b10;
        default:        fwd_a_c = 2'b00;
      endcase
      unique case (1'b1)
        b_mem:          fwd_b_c = 2'b01;
        (b_wb && !b_mem): fwd_b_c = 2'b10;
        default:        fwd_b_c = 2'b00;
      endcase
    end
  end

  assign fwd_a_sel = RST_N ? fwd_a_c : 2'b00;
  assign fwd_b_sel = RST_N ? fwd_b_c : 2'b00;

  logic de1_v;
  logic de2_v;
  logic ex_hit;
  logic mem_hit;
  logic hz;

  assign de1_v = de_rs1_used && (de_rs1 != '0);
  assign de2_v = de_rs2_used && (de_rs2 != '0);

  assign ex_hit = ex_regwrite && (ex_rd != '0) &&
                  ((de1_v && (ex_rd == de_rs1)) ||
                   (de2_v && (ex_rd == de_rs2)));

  assign mem_hit = mem_regwrite && (mem_rd != '0) &&
                   ((de1_v && (mem_rd == de_rs1)) ||
                    (de2_v && (mem_rd == de_rs2)));

  // write-first regfile: WB never needs a stall
  assign hz = (FWD_EN != 0) ? (ex_memread && ex_hit)
                            : (ex_hit || mem_hit);

  logic hold_c;
  logic bubble_c;
  logic flush_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_c   = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_br_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hz) begin
          hold_c   = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = STALL;
            cnt_d   = STALL_INIT;
          end
        end
      end
      STALL: begin
        if (ex_br_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = RUN;
          cnt_d    = 4'd0;
        end else begin
          hold_c   = 1'b1;
          bubble_c = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_hold      = RST_N && hold_c;
  assign if_de_hold   = RST_N && hold_c;
  assign de_ex_bubble = RST_N && bubble_c;
  assign if_de_flush  = RST_N && flush_c;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] fwd_q;
  logic             fwd_any;

  assign fwd_any = (fwd_a_sel != 2'b00) || (fwd_b_sel != 2'b00);

  // counters stick at all-ones instead of wrapping
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_q <= '0;
      flush_q <= '0;
      fwd_q   <= '0;
    end else begin
      if (pc_hold && !(&stall_q)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (if_de_flush && !(&flush_q)) begin
        flush_q <= flush_q + CNT_ONE;
      end
      if (fwd_any && !(&fwd_q)) begin
        fwd_q <= fwd_q + CNT_ONE;
      end
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
  assign fwd_count   = fwd_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
  assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench: three instances (LOAD_STALL=1, LOAD_STALL=3, FWD_EN=0)
// share one stimulus stream.
module tb_hazard_forward_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic de_rs1_used, de_rs2_used, ex_regwrite, ex_memread, ex_br_taken;
  logic mem_regwrite, wb_regwrite;

  logic [1:0] a_fa, a_fb, b_fa, b_fb, c_fa, c_fb;
  logic a_ph, a_ih, a_bb, a_fl;
  logic b_ph, b_ih, b_bb, b_fl;
  logic c_ph, c_ih, c_bb, c_fl;
  logic [15:0] a_sc, a_flc, a_fwc;
  logic [15:0] b_sc, b_flc, b_fwc;
  logic [15:0] c_sc, c_flc, c_fwc;

  int checks = 0;
  int passes = 0;

  always #5 CLK = ~CLK;

  hazard_forward_ctrl u_a (
    .CLK(CLK), .RST_N(RST_N),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a_sel(a_fa), .fwd_b_sel(a_fb),
    .pc_hold(a_ph), .if_de_hold(a_ih),
    .de_ex_bubble(a_bb), .if_de_flush(a_fl),
    .stall_count(a_sc), .flush_count(a_flc), .fwd_count(a_fwc)
  );

  hazard_forward_ctrl #(.LOAD_STALL(3)) u_b (
    .CLK(CLK), .RST_N(RST_N),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
    .pc_hold(b_ph), .if_de_hold(b_ih),
    .de_ex_bubble(b_bb), .if_de_flush(b_fl),
    .stall_count(b_sc), .flush_count(b_flc), .fwd_count(b_fwc)
  );

  hazard_forward_ctrl #(.FWD_EN(0)) u_c (
    .CLK(CLK), .RST_N(RST_N),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a_sel(c_fa), .fwd_b_sel(c_fb),
    .pc_hold(c_ph), .if_de_hold(c_ih),
    .de_ex_bubble(c_bb), .if_de_flush(c_fl),
    .stall_count(c_sc), .flush_count(c_flc), .fwd_count(c_fwc)
  );

  task automatic clr();
    de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_memread = 0; ex_br_taken = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
  endtask

  task automatic next();
    @(negedge CLK);
    clr();
  endtask

  task automatic load_hz();
    ex_rd = 7; ex_regwrite = 1; ex_memread = 1;
    de_rs1 = 7; de_rs1_used = 1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    clr();
    mem_rd = 5; mem_regwrite = 1; ex_rs1 = 5; ex_rs2 = 5;
    load_hz();
    ex_br_taken = 1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (a_fa !== 2'b00) $display("FAIL rst_fwd_a got=%b exp=00", a_fa); else passes++;
    checks++; if (a_fb !== 2'b00) $display("FAIL rst_fwd_b got=%b exp=00", a_fb); else passes++;
    checks++; if ({a_ph, a_ih, a_bb, a_fl} !== 4'b0000) $display("FAIL rst_ctl got=%b exp=0000", {a_ph, a_ih, a_bb, a_fl}); else passes++;
    checks++; if ({b_ph, c_ph, b_fl} !== 3'b000) $display("FAIL rst_ctl_bc got=%b exp=000", {b_ph, c_ph, b_fl}); else passes++;
    checks++; if (a_sc !== 16'd0 || a_flc !== 16'd0 || a_fwc !== 16'd0) $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0/0/0", a_sc, a_flc, a_fwc); else passes++;
    next();
    RST_N = 1'b1;
    #1;
    checks++; if ({a_ph, a_bb, a_fl} !== 3'b000) $display("FAIL rst_rel_ctl got=%b exp=000", {a_ph, a_bb, a_fl}); else passes++;
    checks++; if (b_ph !== 1'b0) $display("FAIL rst_rel_b_hold got=%b exp=0", b_ph); else passes++;
  endtask

  task automatic test_forward();
    next();
    mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
    ex_rs1 = 5; ex_rs2 = 6;
    #1;
    checks++; if (a_fa !== 2'b01) $display("FAIL fwd_mem_prio got=%b exp=01", a_fa); else passes++;
    checks++; if (a_fb !== 2'b00) $display("FAIL fwd_b_none got=%b exp=00", a_fb); else passes++;
    checks++; if (c_fa !== 2'b00) $display("FAIL nofwd_a got=%b exp=00", c_fa); else passes++;
    next();
    mem_rd = 5; mem_regwrite = 0; wb_rd = 5; wb_regwrite = 1;
    ex_rs1 = 5; ex_rs2 = 6;
    #1;
    checks++; if (a_fa !== 2'b10) $display("FAIL fwd_wb got=%b exp=10", a_fa); else passes++;
    next();
    mem_rd = 5; mem_regwrite = 1; wb_rd = 6; wb_regwrite = 1;
    ex_rs1 = 5; ex_rs2 = 6;
    #1;
    checks++; if ({a_fa, a_fb} !== 4'b0110) $display("FAIL fwd_split got=%b exp=0110", {a_fa, a_fb}); else passes++;
    next();
    mem_rd = 6; mem_regwrite = 1; wb_rd = 6; wb_regwrite = 1;
    ex_rs1 = 5; ex_rs2 = 6;
    #1;
    checks++; if ({a_fa, a_fb} !== 4'b0001) $display("FAIL fwd_b_mem got=%b exp=0001", {a_fa, a_fb}); else passes++;
  endtask

  task automatic test_x0();
    next();
    ex_rs1 = 0; ex_rs2 = 0;
    mem_rd = 0; mem_regwrite = 1; wb_rd = 0; wb_regwrite = 1;
    de_rs1 = 0; de_rs2 = 0; de_rs1_used = 1; de_rs2_used = 1;
    ex_rd = 0; ex_regwrite = 1; ex_memread = 1;
    #1;
    checks++; if ({a_fa, a_fb} !== 4'b0000) $display("FAIL x0_fwd got=%b exp=0000", {a_fa, a_fb}); else passes++;
    checks++; if ({a_ph, b_ph, c_ph} !== 3'b000) $display("FAIL x0_hz got=%b exp=000", {a_ph, b_ph, c_ph}); else passes++;
    next();
    #1;
    checks++; if (a_fwc !== 16'(4 * P)) $display("FAIL fwd_cnt got=%0d exp=%0d", a_fwc, 4 * P); else passes++;
  endtask

  task automatic test_load_stall();
    next();
    load_hz();
    #1;
    checks++; if ({a_ph, a_ih, a_bb, a_fl} !== 4'b1110) $display("FAIL ld_a_ctl got=%b exp=1110", {a_ph, a_ih, a_bb, a_fl}); else passes++;
    checks++; if ({b_ph, c_ph} !== 2'b11) $display("FAIL ld_bc_hold got=%b exp=11", {b_ph, c_ph}); else passes++;
    next();
    #1;
    checks++; if (a_ph !== 1'b0) $display("FAIL ld1_a_release got=%b exp=0", a_ph); else passes++;
    checks++; if ({b_ph, b_ih, b_bb} !== 3'b111) $display("FAIL ld3_cyc2 got=%b exp=111", {b_ph, b_ih, b_bb}); else passes++;
    next();
    #1;
    checks++; if (b_ph !== 1'b1) $display("FAIL ld3_cyc3 got=%b exp=1", b_ph); else passes++;
    next();
    #1;
    checks++; if ({b_ph, b_bb} !== 2'b00) $display("FAIL ld3_done got=%b exp=00", {b_ph, b_bb}); else passes++;
    checks++; if (a_sc !== 16'(P) || b_sc !== 16'(3 * P)) $display("FAIL ld_stall_cnt got=%0d/%0d exp=%0d/%0d", a_sc, b_sc, P, 3 * P); else passes++;
    next();
    ex_rd = 7; ex_regwrite = 1; ex_memread = 1;
    de_rs2 = 7; de_rs2_used = 0; de_rs1 = 3; de_rs1_used = 1;
    #1;
    checks++; if ({a_ph, b_ph, c_ph} !== 3'b000) $display("FAIL unused_src got=%b exp=000", {a_ph, b_ph, c_ph}); else passes++;
  endtask

  task automatic test_branch();
    next();
    load_hz();
    ex_br_taken = 1;
    #1;
    checks++; if ({a_ph, a_ih, a_bb, a_fl} !== 4'b0011) $display("FAIL br_prio got=%b exp=0011", {a_ph, a_ih, a_bb, a_fl}); else passes++;
    checks++; if ({b_ph, b_fl, c_ph} !== 3'b010) $display("FAIL br_prio_bc got=%b exp=010", {b_ph, b_fl, c_ph}); else passes++;
    next();
    #1;
    checks++; if (a_flc !== 16'(P)) $display("FAIL br_flush_cnt got=%0d exp=%0d", a_flc, P); else passes++;
    checks++; if ({a_fl, b_ph} !== 2'b00) $display("FAIL br_after got=%b exp=00", {a_fl, b_ph}); else passes++;
    next();
    load_hz();
    #1;
    checks++; if (b_ph !== 1'b1) $display("FAIL abort_enter got=%b exp=1", b_ph); else passes++;
    next();
    ex_br_taken = 1;
    #1;
    checks++; if ({b_ph, b_ih, b_bb, b_fl} !== 4'b0011) $display("FAIL abort_stall got=%b exp=0011", {b_ph, b_ih, b_bb, b_fl}); else passes++;
    next();
    #1;
    checks++; if ({b_ph, b_bb} !== 2'b00) $display("FAIL abort_run got=%b exp=00", {b_ph, b_bb}); else passes++;
  endtask

  task automatic test_nofwd();
    next();
    mem_rd = 4; mem_regwrite = 1; ex_rs2 = 4;
    de_rs2 = 4; de_rs2_used = 1;
    #1;
    checks++; if ({c_ph, c_ih, c_bb} !== 3'b111) $display("FAIL nofwd_mem_hz got=%b exp=111", {c_ph, c_ih, c_bb}); else passes++;
    checks++; if ({c_fa, c_fb} !== 4'b0000) $display("FAIL nofwd_sel got=%b exp=0000", {c_fa, c_fb}); else passes++;
    checks++; if ({a_ph, a_fb} !== 3'b001) $display("FAIL fwd_mode_mem got=%b exp=001", {a_ph, a_fb}); else passes++;
    next();
    #1;
    checks++; if (c_ph !== 1'b0) $display("FAIL nofwd_1cyc got=%b exp=0", c_ph); else passes++;
    next();
    ex_rd = 9; ex_regwrite = 1; de_rs1 = 9; de_rs1_used = 1;
    #1;
    checks++; if ({c_ph, a_ph} !== 2'b10) $display("FAIL nofwd_ex_hz got=%b exp=10", {c_ph, a_ph}); else passes++;
    next();
    #1;
    checks++; if (a_sc !== 16'(2 * P) || a_flc !== 16'(2 * P)) $display("FAIL tot_a got=%0d/%0d exp=%0d/%0d", a_sc, a_flc, 2 * P, 2 * P); else passes++;
    checks++; if (a_fwc !== 16'(5 * P)) $display("FAIL tot_fwd got=%0d exp=%0d", a_fwc, 5 * P); else passes++;
    checks++; if (b_sc !== 16'(4 * P) || c_sc !== 16'(4 * P)) $display("FAIL tot_bc got=%0d/%0d exp=%0d/%0d", b_sc, c_sc, 4 * P, 4 * P); else passes++;
  endtask

  task automatic test_reset_mid_stall();
    next();
    load_hz();
    #1;
    checks++; if (b_ph !== 1'b1) $display("FAIL mid_cyc1 got=%b exp=1", b_ph); else passes++;
    next();
    #1;
    checks++; if (b_ph !== 1'b1) $display("FAIL mid_cyc2 got=%b exp=1", b_ph); else passes++;
    RST_N = 1'b0;
    #1;
    checks++; if ({b_ph, b_ih, b_bb, b_fl} !== 4'b0000) $display("FAIL mid_rst_ctl got=%b exp=0000", {b_ph, b_ih, b_bb, b_fl}); else passes++;
    next();
    RST_N = 1'b1;
    #1;
    checks++; if ({b_ph, b_bb} !== 2'b00) $display("FAIL mid_rst_run got=%b exp=00", {b_ph, b_bb}); else passes++;
    checks++; if (a_sc !== 16'd0 || a_flc !== 16'd0 || a_fwc !== 16'd0 || b_sc !== 16'd0) $display("FAIL mid_rst_cnt got=%0d/%0d/%0d/%0d exp=0/0/0/0", a_sc, a_flc, a_fwc, b_sc); else passes++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_x0();
    test_load_stall();
    test_branch();
    test_nofwd();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
